// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: FSM encodings and PC constants.
package fetch_pc_sequencer_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StDrain  = 2'b01,
        StHalted = 2'b10
    } fetch_state_e;

    // Default PC loaded on reset
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    // Sequential fetch step (16-bit instructions)
    localparam logic [15:0] PC_INC = 16'd2;

endpackage

// File: rtl/cla16b.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
module cla16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] gen;
    logic [15:0] prop;
    logic [16:0] carry;
    logic [3:0]  grp_gen;
    logic [3:0]  grp_prop;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Group generate/propagate terms
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            grp_prop[k] = prop[4*k] & prop[4*k+1] & prop[4*k+2] & prop[4*k+3];
            grp_gen[k]  = gen[4*k+3]
                        | (prop[4*k+3] & gen[4*k+2])
                        | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                        | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
        end
    end

    // Group carries come from the lookahead unit; bit carries are resolved inside each group
    always_comb begin
        carry[0]  = cin;
        carry[4]  = grp_gen[0] | (grp_prop[0] & cin);
        carry[8]  = grp_gen[1] | (grp_prop[1] & grp_gen[0]) | (grp_prop[1] & grp_prop[0] & cin);
        carry[12] = grp_gen[2] | (grp_prop[2] & grp_gen[1]) | (grp_prop[2] & grp_prop[1] & grp_gen[0])
                  | (grp_prop[2] & grp_prop[1] & grp_prop[0] & cin);
        carry[16] = grp_gen[3] | (grp_prop[3] & grp_gen[2]) | (grp_prop[3] & grp_prop[2] & grp_gen[1])
                  | (grp_prop[3] & grp_prop[2] & grp_prop[1] & grp_gen[0])
                  | (grp_prop[3] & grp_prop[2] & grp_prop[1] & grp_prop[0] & cin);
        for (int k = 0; k < 4; k++) begin
            carry[4*k+1] = gen[4*k] | (prop[4*k] & carry[4*k]);
            carry[4*k+2] = gen[4*k+1] | (prop[4*k+1] & gen[4*k])
                         | (prop[4*k+1] & prop[4*k] & carry[4*k]);
            carry[4*k+3] = gen[4*k+2] | (prop[4*k+2] & gen[4*k+1])
                         | (prop[4*k+2] & prop[4*k+1] & gen[4*k])
                         | (prop[4*k+2] & prop[4*k+1] & prop[4*k] & carry[4*k]);
        end
    end

    // Sum bits
    always_comb begin
        sum  = prop ^ carry[15:0];
        cout = carry[16];
    end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: owns the fetch PC, drives the imem handshake and applies
// redirects, stalls and HALT, including those arriving while a fetch is outstanding.
module fetch_pc_sequencer
    import fetch_pc_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    output logic            if_valid,
    output logic [PC_W-1:0] if_pc,
    output logic [PC_W-1:0] if_pc_plus2,
    output logic            flush,
    output logic            halted
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    logic            halt_pend_q, halt_pend_d;

    logic [PC_W-1:0] pc_plus2;
    logic            pc_inc_cout_unused;
    logic            if_valid_raw;
    logic            flush_raw;

    cla16b u_pc_inc (
        .a    (pc_q),
        .b    (PC_INC),
        .cin  (1'b0),
        .sum  (pc_plus2),
        .cout (pc_inc_cout_unused)
    );

    // Next-state, next-PC mux and the combinational pipeline controls
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        halt_pend_d  = halt_pend_q;
        if_valid_raw = 1'b0;
        flush_raw    = 1'b0;

        unique case (state_q)
            StRun: begin
                if (redirect) begin
                    flush_raw = 1'b1;
                    if (imem_ready) begin
                        pc_d = redirect_pc;
                    end else begin
                        pend_pc_d   = redirect_pc;
                        halt_pend_d = 1'b0;
                        state_d     = StDrain;
                    end
                end else if (halt) begin
                    flush_raw = 1'b1;
                    if (imem_ready) begin
                        state_d = StHalted;
                    end else begin
                        halt_pend_d = 1'b1;
                        state_d     = StDrain;
                    end
                end else if (stall) begin
                    // Hold pc; the same address is refetched next cycle
                end else if (imem_ready) begin
                    if_valid_raw = 1'b1;
                    pc_d         = pc_plus2;
                end
            end

            StDrain: begin
                // The outstanding fetch is wrong-path; keep its address stable until ready
                if (redirect) begin
                    pend_pc_d   = redirect_pc;
                    halt_pend_d = 1'b0;
                    flush_raw   = 1'b1;
                end else if (halt) begin
                    halt_pend_d = 1'b1;
                end
                if (imem_ready) begin
                    if (halt_pend_d) begin
                        state_d = StHalted;
                    end else begin
                        pc_d    = pend_pc_d;
                        state_d = StRun;
                    end
                end
            end

            StHalted: begin
                // Only reset leaves HALTED
            end

            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Architectural state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            pend_pc_q   <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_pc_q   <= pend_pc_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // Outputs; controls are forced quiet while reset is asserted
    always_comb begin
        imem_req    = rst_n & (state_q != StHalted);
        imem_addr   = pc_q;
        if_pc       = pc_q;
        if_pc_plus2 = pc_plus2;
        if_valid    = rst_n & if_valid_raw;
        flush       = rst_n & flush_raw;
        halted      = rst_n & (state_q == StHalted);
    end

endmodule
